// File: rtl/rob_commit_if.sv
// Pipeline <-> reorder buffer bundle: dispatch, writeback, commit and redirect signals.
// Optional commit_cnt exists only when ROB_COMMIT_CNT_EN is defined.
interface rob_commit_if #(
   parameter int ROB_DEPTH = 16
);
   localparam int IDX_W = $clog2(ROB_DEPTH);

   logic             dispatch_valid;
   logic [31:0]      dispatch_pc;
   logic [4:0]       dispatch_dst;
   logic             dispatch_wen;
   logic             dispatch_eret;
   logic [IDX_W-1:0] dispatch_tag;
   logic             rob_full;

   logic             wb_valid;
   logic [IDX_W-1:0] wb_tag;
   logic [31:0]      wb_data;
   logic             wb_mispredict;
   logic [31:0]      wb_target;
   logic             wb_exc;
   logic [4:0]       wb_exccode;

   logic             commit_valid;
   logic             commit_wen;
   logic [4:0]       commit_dst;
   logic [31:0]      commit_data;
   logic [31:0]      commit_pc;
   logic             branch_taken;
   logic [31:0]      redirect_pc;
   logic             exception_valid;
   logic             is_eret;
   logic [4:0]       exc_code;
`ifdef ROB_COMMIT_CNT_EN
   logic [31:0]      commit_cnt;
`endif

   modport slave (
      input  dispatch_valid, dispatch_pc, dispatch_dst, dispatch_wen, dispatch_eret,
      input  wb_valid, wb_tag, wb_data, wb_mispredict, wb_target, wb_exc, wb_exccode,
      output dispatch_tag, rob_full,
      output commit_valid, commit_wen, commit_dst, commit_data, commit_pc,
      output branch_taken, redirect_pc, exception_valid, is_eret, exc_code
`ifdef ROB_COMMIT_CNT_EN
      , output commit_cnt
`endif
   );

   modport master (
      output dispatch_valid, dispatch_pc, dispatch_dst, dispatch_wen, dispatch_eret,
      output wb_valid, wb_tag, wb_data, wb_mispredict, wb_target, wb_exc, wb_exccode,
      input  dispatch_tag, rob_full,
      input  commit_valid, commit_wen, commit_dst, commit_data, commit_pc,
      input  branch_taken, redirect_pc, exception_valid, is_eret, exc_code
`ifdef ROB_COMMIT_CNT_EN
      , input commit_cnt
`endif
   );
endinterface

// File: rtl/rob_commit.sv
// In-order reorder buffer: dispatch at tail, writeback by tag, one retire per cycle from head.
// Commit outputs are combinational from head; define ROB_COMMIT_CNT_EN to add commit_cnt.
module rob_commit #(
   parameter int ROB_DEPTH = 16
) (
   input logic clk,
   input logic reset,
   rob_commit_if.slave bus
);
   localparam int IDX_W = $clog2(ROB_DEPTH);
   localparam logic [IDX_W:0] PTR_ONE   = {{IDX_W{1'b0}}, 1'b1};
   localparam logic [IDX_W:0] DEPTH_CNT = {1'b1, {IDX_W{1'b0}}};
   localparam logic [31:0]    EXC_VEC   = 32'hBFC0_0380;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [IDX_W:0]     r_head, r_tail;
   logic [ROB_DEPTH-1:0] r_valid, r_done;
   logic [ROB_DEPTH-1:0] r_wen, r_eret, r_mis, r_exc;
   logic [31:0]        r_pc   [ROB_DEPTH];
   logic [31:0]        r_data [ROB_DEPTH];
   logic [31:0]        r_tgt  [ROB_DEPTH];
   logic [4:0]         r_dst  [ROB_DEPTH];
   logic [4:0]         r_code [ROB_DEPTH];

   logic [IDX_W:0]     w_count;
   logic [IDX_W-1:0]   w_hidx, w_tidx;
   logic               w_full, w_cv, w_h_exc, w_h_eret, w_h_mis;
   logic               w_norm, w_flush, w_acc, w_wb;

   assign w_count  = r_tail - r_head;
   assign w_full   = (w_count == DEPTH_CNT);
   assign w_hidx   = r_head[IDX_W-1:0];
   assign w_tidx   = r_tail[IDX_W-1:0];

   assign w_cv     = r_valid[w_hidx] & r_done[w_hidx];
   assign w_h_exc  = r_exc[w_hidx];
   assign w_h_eret = r_eret[w_hidx];
   assign w_h_mis  = r_mis[w_hidx];
   assign w_norm   = w_cv & ~w_h_exc & ~w_h_eret;
   assign w_flush  = w_cv & (w_h_exc | w_h_eret | w_h_mis);

   // A redirect cycle drops any dispatch or writeback arriving with it.
   assign w_acc    = bus.dispatch_valid & ~w_full & ~w_flush;
   assign w_wb     = bus.wb_valid & r_valid[bus.wb_tag] & ~w_flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_valid <= '0;
         r_done  <= '0;
      end else if (w_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_valid <= '0;
         r_done  <= '0;
      end else begin
         if (w_acc) begin
            r_valid[w_tidx] <= 1'b1;
            r_done[w_tidx]  <= 1'b0;
            r_tail          <= r_tail + PTR_ONE;
         end
         if (w_wb) begin
            r_done[bus.wb_tag] <= 1'b1;
         end
         if (w_cv) begin
            r_valid[w_hidx] <= 1'b0;
            r_head          <= r_head + PTR_ONE;
         end
      end
   end

   // Payload needs no reset: nothing reads it until the valid/done bits allow.
   always_ff @(posedge clk) begin
      if (w_acc) begin
         r_pc[w_tidx]   <= bus.dispatch_pc;
         r_dst[w_tidx]  <= bus.dispatch_dst;
         r_wen[w_tidx]  <= bus.dispatch_wen;
         r_eret[w_tidx] <= bus.dispatch_eret;
      end
      if (w_wb) begin
         r_data[bus.wb_tag] <= bus.wb_data;
         r_mis[bus.wb_tag]  <= bus.wb_mispredict;
         r_tgt[bus.wb_tag]  <= bus.wb_target;
         r_exc[bus.wb_tag]  <= bus.wb_exc;
         r_code[bus.wb_tag] <= bus.wb_exccode;
      end
   end

   assign bus.dispatch_tag    = w_tidx;
   assign bus.rob_full        = w_full;
   assign bus.commit_valid    = w_cv;
   assign bus.commit_wen      = w_norm & r_wen[w_hidx];
   assign bus.commit_dst      = w_cv ? r_dst[w_hidx]  : 5'd0;
   assign bus.commit_data     = w_cv ? r_data[w_hidx] : 32'd0;
   assign bus.commit_pc       = w_cv ? r_pc[w_hidx]   : 32'd0;
   assign bus.branch_taken    = w_norm & w_h_mis;
   assign bus.exception_valid = w_cv & (w_h_exc | w_h_eret);
   assign bus.is_eret         = w_cv & ~w_h_exc & w_h_eret;
   assign bus.exc_code        = (w_cv & w_h_exc) ? r_code[w_hidx] : 5'd0;

   // ERET's return address comes from CP0 outside this block, so no target here.
   always_comb begin
      bus.redirect_pc = 32'd0;
      if (w_cv) begin
         if (w_h_exc)
            bus.redirect_pc = EXC_VEC;
         else if (!w_h_eret && w_h_mis)
            bus.redirect_pc = r_tgt[w_hidx];
      end
   end

`ifdef ROB_COMMIT_CNT_EN
   logic [31:0] r_commit_cnt;

   always_ff @(posedge clk) begin
      if (reset)
         r_commit_cnt <= 32'd0;
      else if (w_norm)
         r_commit_cnt <= r_commit_cnt + 32'd1;
   end

   assign bus.commit_cnt = r_commit_cnt;
`endif
endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed table, corner sequences and random traffic vs a queue model.
// Optional commit_cnt checks compile in when ROB_COMMIT_CNT_EN is defined.
module tb_rob_commit;
   localparam int D = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rob_commit_if #(.ROB_DEPTH(D)) bus ();
   rob_commit #(.ROB_DEPTH(D)) dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct {
      bit          rst, dv, wen, eret, wbv, mis, exc;
      logic [31:0] pc, data, tgt;
      logic [4:0]  dst, code;
      logic [3:0]  wbtag;
   } stim_t;

   typedef struct {
      stim_t       s;
      logic [3:0]  tag;
      bit          full, cv, wen;
      logic [4:0]  dst;
      logic [31:0] data, pc;
   } vec_t;

   typedef struct {
      logic [31:0] pc, data, tgt;
      logic [4:0]  dst, code;
      bit          wen, eret, done, mis, exc;
   } ent_t;

   ent_t mq[$];
   int   mhead;
   logic [31:0] mcnt;
   int   checks = 0;
   int   errors = 0;
   vec_t tbl[9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '{default: 0};
      return s;
   endfunction

   function automatic stim_t sd(input logic [31:0] pc, input logic [4:0] dst, input bit wen);
      stim_t s = idle();
      s.dv = 1; s.pc = pc; s.dst = dst; s.wen = wen;
      return s;
   endfunction

   function automatic stim_t sw(input logic [3:0] tag, input logic [31:0] data, input bit mis,
                                input logic [31:0] tgt, input bit exc, input logic [4:0] code);
      stim_t s = idle();
      s.wbv = 1; s.wbtag = tag; s.data = data; s.mis = mis; s.tgt = tgt; s.exc = exc; s.code = code;
      return s;
   endfunction

   function automatic stim_t srst();
      stim_t s = idle();
      s.rst = 1;
      return s;
   endfunction

   // Reference: a FIFO of in-flight instructions; the head tag advances mod D on retire.
   task automatic model_step(input stim_t s);
      bit   cv, redirect, acc;
      int   k;
      ent_t e;
      if (s.rst) begin
         mq.delete(); mhead = 0; mcnt = 0;
         return;
      end
      cv = (mq.size() > 0) && mq[0].done;
      redirect = cv && (mq[0].exc || mq[0].eret || mq[0].mis);
      if (cv && !mq[0].exc && !mq[0].eret) mcnt = mcnt + 1;
      if (redirect) begin
         mq.delete(); mhead = 0;
         return;
      end
      acc = s.dv && (mq.size() < D);
      if (s.wbv) begin
         k = (int'(s.wbtag) - mhead + D) % D;
         if (k < mq.size()) begin
            e = mq[k];
            e.data = s.data; e.mis = s.mis; e.tgt = s.tgt; e.exc = s.exc; e.code = s.code;
            e.done = 1;
            mq[k] = e;
         end
      end
      if (cv) begin
         void'(mq.pop_front());
         mhead = (mhead + 1) % D;
      end
      if (acc) begin
         e = '{pc: s.pc, data: 0, tgt: 0, dst: s.dst, code: 0, wen: s.wen, eret: s.eret,
               done: 0, mis: 0, exc: 0};
         mq.push_back(e);
      end
   endtask

   task automatic check_model();
      bit   cv;
      ent_t e;
      cv = (mq.size() > 0) && mq[0].done;
      e = '{default: 0};
      if (mq.size() > 0) e = mq[0];
      chk("m_tag", 32'(bus.dispatch_tag), 32'((mhead + mq.size()) % D));
      chk("m_full", 32'(bus.rob_full), 32'(mq.size() == D));
      chk("m_cv", 32'(bus.commit_valid), 32'(cv));
      chk("m_wen", 32'(bus.commit_wen), 32'(cv && e.wen && !e.exc && !e.eret));
      chk("m_br", 32'(bus.branch_taken), 32'(cv && !e.exc && !e.eret && e.mis));
      chk("m_exv", 32'(bus.exception_valid), 32'(cv && (e.exc || e.eret)));
      chk("m_eret", 32'(bus.is_eret), 32'(cv && !e.exc && e.eret));
      if (cv) begin
         chk("m_dst", 32'(bus.commit_dst), 32'(e.dst));
         chk("m_data", bus.commit_data, e.data);
         chk("m_pc", bus.commit_pc, e.pc);
         if (e.exc) begin
            chk("m_code", 32'(bus.exc_code), 32'(e.code));
            chk("m_rpc_exc", bus.redirect_pc, 32'hBFC0_0380);
         end else if (!e.eret && e.mis) begin
            chk("m_rpc_br", bus.redirect_pc, e.tgt);
         end
      end
`ifdef ROB_COMMIT_CNT_EN
      chk("m_cnt", bus.commit_cnt, mcnt);
`endif
   endtask

   task automatic apply(input stim_t s);
      reset              = s.rst;
      bus.dispatch_valid = s.dv;
      bus.dispatch_pc    = s.pc;
      bus.dispatch_dst   = s.dst;
      bus.dispatch_wen   = s.wen;
      bus.dispatch_eret  = s.eret;
      bus.wb_valid       = s.wbv;
      bus.wb_tag         = s.wbtag;
      bus.wb_data        = s.data;
      bus.wb_mispredict  = s.mis;
      bus.wb_target      = s.tgt;
      bus.wb_exc         = s.exc;
      bus.wb_exccode     = s.code;
      @(posedge clk);
      model_step(s);
      @(negedge clk);
   endtask

   initial begin
      stim_t s;
      mhead = 0; mcnt = 0;
      apply(srst());
      apply(srst());

      // Reset state
      chk("rst_tag", 32'(bus.dispatch_tag), 32'd0);
      chk("rst_full", 32'(bus.rob_full), 32'd0);
      chk("rst_cv", 32'(bus.commit_valid), 32'd0);
      chk("rst_wen", 32'(bus.commit_wen), 32'd0);
      chk("rst_br", 32'(bus.branch_taken), 32'd0);
      chk("rst_exv", 32'(bus.exception_valid), 32'd0);
      chk("rst_eret", 32'(bus.is_eret), 32'd0);
      chk("rst_code", 32'(bus.exc_code), 32'd0);
      chk("rst_rpc", bus.redirect_pc, 32'd0);
      chk("rst_pc", bus.commit_pc, 32'd0);

      // Three dispatches, writebacks 2,0,1, in-order retire on consecutive cycles
      tbl[0] = '{sd(32'h100, 5'd1, 1), 4'd0, 0, 0, 0, 5'd0, 32'h0, 32'h0};
      tbl[1] = '{sd(32'h104, 5'd2, 1), 4'd1, 0, 0, 0, 5'd0, 32'h0, 32'h0};
      tbl[2] = '{sd(32'h108, 5'd3, 1), 4'd2, 0, 0, 0, 5'd0, 32'h0, 32'h0};
      tbl[3] = '{sw(4'd2, 32'hC, 0, 0, 0, 0), 4'd3, 0, 0, 0, 5'd0, 32'h0, 32'h0};
      tbl[4] = '{sw(4'd0, 32'hA, 0, 0, 0, 0), 4'd3, 0, 0, 0, 5'd0, 32'h0, 32'h0};
      tbl[5] = '{sw(4'd1, 32'hB, 0, 0, 0, 0), 4'd3, 0, 1, 1, 5'd1, 32'hA, 32'h100};
      tbl[6] = '{idle(), 4'd3, 0, 1, 1, 5'd2, 32'hB, 32'h104};
      tbl[7] = '{idle(), 4'd3, 0, 1, 1, 5'd3, 32'hC, 32'h108};
      tbl[8] = '{idle(), 4'd3, 0, 0, 0, 5'd0, 32'h0, 32'h0};
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("t%0d_tag", i), 32'(bus.dispatch_tag), 32'(tbl[i].tag));
         chk($sformatf("t%0d_full", i), 32'(bus.rob_full), 32'(tbl[i].full));
         chk($sformatf("t%0d_cv", i), 32'(bus.commit_valid), 32'(tbl[i].cv));
         chk($sformatf("t%0d_wen", i), 32'(bus.commit_wen), 32'(tbl[i].wen));
         if (tbl[i].cv) begin
            chk($sformatf("t%0d_dst", i), 32'(bus.commit_dst), 32'(tbl[i].dst));
            chk($sformatf("t%0d_data", i), bus.commit_data, tbl[i].data);
            chk($sformatf("t%0d_pc", i), bus.commit_pc, tbl[i].pc);
         end
         apply(tbl[i].s);
      end
      check_model();

      // Fill to 16, 17th ignored, retire head, wrap to tag 0
      apply(srst());
      for (int i = 0; i < D; i++) apply(sd(32'h1000 + 32'(4 * i), 5'(i), 1));
      chk("fill_full", 32'(bus.rob_full), 32'd1);
      chk("fill_tag", 32'(bus.dispatch_tag), 32'd0);
      apply(sd(32'hDEAD, 5'd31, 1));
      chk("ovf_full", 32'(bus.rob_full), 32'd1);
      chk("ovf_tag", 32'(bus.dispatch_tag), 32'd0);
      check_model();
      apply(sw(4'd0, 32'h55, 0, 0, 0, 0));
      chk("hd_cv", 32'(bus.commit_valid), 32'd1);
      chk("hd_pc", bus.commit_pc, 32'h1000);
      chk("hd_data", bus.commit_data, 32'h55);
      apply(idle());
      chk("hd_full", 32'(bus.rob_full), 32'd0);
      chk("hd_tag", 32'(bus.dispatch_tag), 32'd0);
      apply(sd(32'h2000, 5'd4, 1));
      chk("wrap_full", 32'(bus.rob_full), 32'd1);
      chk("wrap_tag", 32'(bus.dispatch_tag), 32'd1);
      check_model();

      // Mispredict at head with a second completed entry behind it
      apply(srst());
      apply(sd(32'h300, 5'd7, 1));
      apply(sd(32'h304, 5'd8, 1));
      apply(sw(4'd1, 32'h77, 0, 0, 0, 0));
      apply(sw(4'd0, 32'h66, 1, 32'h200, 0, 0));
      chk("mp_cv", 32'(bus.commit_valid), 32'd1);
      chk("mp_wen", 32'(bus.commit_wen), 32'd1);
      chk("mp_br", 32'(bus.branch_taken), 32'd1);
      chk("mp_rpc", bus.redirect_pc, 32'h200);
      chk("mp_exv", 32'(bus.exception_valid), 32'd0);
      apply(idle());
      chk("mp_br1", 32'(bus.branch_taken), 32'd0);
      chk("mp_cv1", 32'(bus.commit_valid), 32'd0);
      chk("mp_tag1", 32'(bus.dispatch_tag), 32'd0);
      check_model();

      // Exception at head with a concurrent dispatch that must be dropped
      apply(srst());
      apply(sd(32'h400, 5'd9, 1));
      apply(sw(4'd0, 32'h88, 0, 0, 1, 5'h04));
      chk("ex_cv", 32'(bus.commit_valid), 32'd1);
      chk("ex_wen", 32'(bus.commit_wen), 32'd0);
      chk("ex_exv", 32'(bus.exception_valid), 32'd1);
      chk("ex_code", 32'(bus.exc_code), 32'd4);
      chk("ex_rpc", bus.redirect_pc, 32'hBFC0_0380);
      chk("ex_eret", 32'(bus.is_eret), 32'd0);
      apply(sd(32'h500, 5'd10, 1));
      chk("ex_tag1", 32'(bus.dispatch_tag), 32'd0);
      chk("ex_exv1", 32'(bus.exception_valid), 32'd0);
      apply(sw(4'd0, 32'h99, 0, 0, 0, 0));
      apply(idle());
      chk("ex_drop_cv", 32'(bus.commit_valid), 32'd0);
      check_model();

      // ERET
      apply(srst());
      s = sd(32'h600, 5'd11, 1);
      s.eret = 1;
      apply(s);
      apply(sw(4'd0, 32'h1, 0, 0, 0, 0));
      chk("er_exv", 32'(bus.exception_valid), 32'd1);
      chk("er_eret", 32'(bus.is_eret), 32'd1);
      chk("er_wen", 32'(bus.commit_wen), 32'd0);
      apply(idle());
      chk("er_cv1", 32'(bus.commit_valid), 32'd0);

`ifdef ROB_COMMIT_CNT_EN
      apply(srst());
      for (int i = 0; i < 6; i++) apply(sd(32'h700 + 32'(4 * i), 5'(i + 1), 1));
      for (int i = 0; i < 5; i++) apply(sw(4'(i), 32'(i), 0, 0, 0, 0));
      apply(sw(4'd5, 32'h0, 0, 0, 1, 5'h0C));
      for (int i = 0; i < 8; i++) apply(idle());
      chk("cnt5", bus.commit_cnt, 32'd5);
`endif

      // Random traffic against the queue model
      apply(srst());
      for (int n = 0; n < 2500; n++) begin
         int k;
         check_model();
         s = idle();
         s.rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 99) < 65) begin
            s.dv = 1; s.pc = $urandom; s.dst = 5'($urandom); s.wen = 1'($urandom);
            s.eret = ($urandom_range(0, 99) < 3);
         end
         if (mq.size() > 0 && $urandom_range(0, 99) < 55) begin
            k = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, mq.size() - 1);
            s.wbv = 1; s.wbtag = 4'((mhead + k) % D);
         end else if ($urandom_range(0, 99) < 10) begin
            s.wbv = 1; s.wbtag = 4'($urandom);
         end
         s.data = $urandom; s.tgt = $urandom; s.code = 5'($urandom);
         s.mis = ($urandom_range(0, 99) < 8);
         s.exc = ($urandom_range(0, 99) < 4);
         apply(s);
      end
      check_model();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
